// File: rtl/ncl_arb_pkg.sv
// Shared definitions for the clocked NCL arbitrating merge: dual-rail digit codes,
// controller states and whole-word classification helpers.
package ncl_arb_pkg;

  localparam logic [1:0] DIG_NULL = 2'b00;
  localparam logic [1:0] DIG_D0   = 2'b01;
  localparam logic [1:0] DIG_D1   = 2'b10;
  localparam logic [1:0] DIG_ILL  = 2'b11;

  // Helpers work on a widest-case word; only the low w digits are examined.
  localparam int MAX_W = 64;
  typedef logic [2*MAX_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RELEASE
  } state_e;

  function automatic logic is_data_word(input word_t word, input int w);
    logic ok;
    ok = 1'b1;
    for (int j = 0; j < MAX_W; j++) begin
      if (j < w && !(word[2*j +: 2] == DIG_D0 || word[2*j +: 2] == DIG_D1)) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic is_null_word(input word_t word, input int w);
    logic ok;
    ok = 1'b1;
    for (int j = 0; j < MAX_W; j++) begin
      if (j < w && word[2*j +: 2] != DIG_NULL) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic has_illegal(input word_t word, input int w);
    logic bad;
    bad = 1'b0;
    for (int j = 0; j < MAX_W; j++) begin
      if (j < w && word[2*j +: 2] == DIG_ILL) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/ncl_rr_pick.sv
// Single-cycle winner selection among eligible channels, searching upward from the
// slot after ptr (round-robin) or from index 0 (fixed priority).
module ncl_rr_pick #(
  parameter int N_CH          = 4,
  parameter int PRIORITY_MODE = 0,
  localparam int IW           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] elig,
  input  logic [IW-1:0]   ptr,
  output logic [N_CH-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            valid
);

  // Fixed priority is round-robin with the pointer pinned to the last slot.
  logic [IW-1:0] start;
  assign start = (PRIORITY_MODE != 0) ? IW'(N_CH - 1) : ptr;

  always_comb begin
    win_idx = '0;
    valid   = 1'b0;
    win_oh  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      if (!valid && elig[(int'(start) + k) % N_CH]) begin
        valid   = 1'b1;
        win_idx = IW'((int'(start) + k) % N_CH);
      end
    end
    if (valid) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/ncl_sync_rr_merge.sv
// Clocked N-channel merge of dual-rail four-phase channels onto one dual-rail output,
// with input synchronisers, illegal-code flagging and round-robin/fixed arbitration.
//
// state   | meaning
// IDLE    | no transfer; grant when downstream requests DATA and a channel is complete
// DATA    | winner word held on out_data; wait for downstream NULL request and winner NULL
// RELEASE | out_data returned to NULL; wait for downstream to request DATA again
module ncl_sync_rr_merge
  import ncl_arb_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int W             = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int PRIORITY_MODE = 0,
  localparam int IW           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  init,
  input  logic [N_CH*2*W-1:0]   in_data,
  output logic [N_CH-1:0]       in_comp,
  output logic [2*W-1:0]        out_data,
  input  logic                  out_comp,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  err_ill
);

  localparam int DW = 2 * W;

  logic [N_CH*DW-1:0] in_data_s;
  logic               out_comp_s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign in_data_s  = in_data;
    assign out_comp_s = out_comp;
  end else begin : g_sync
    logic [N_CH*DW-1:0]   dsync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] csync_q;

    always_ff @(posedge clk) begin
      if (init) begin
        for (int k = 0; k < SYNC_STAGES; k++) dsync_q[k] <= '0;
        csync_q <= '0;
      end else begin
        dsync_q[0] <= in_data;
        csync_q[0] <= out_comp;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          dsync_q[k] <= dsync_q[k-1];
          csync_q[k] <= csync_q[k-1];
        end
      end
    end

    assign in_data_s  = dsync_q[SYNC_STAGES-1];
    assign out_comp_s = csync_q[SYNC_STAGES-1];
  end

  logic [N_CH-1:0] data_cpl, null_cpl, ill_ch;

  for (genvar i = 0; i < N_CH; i++) begin : g_cls
    word_t ext;
    always_comb begin
      ext         = '0;
      ext[DW-1:0] = in_data_s[i*DW +: DW];
    end
    assign data_cpl[i] = is_data_word(ext, W);
    assign null_cpl[i] = is_null_word(ext, W);
    assign ill_ch[i]   = has_illegal(ext, W);
  end

  state_e          state_q, state_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [N_CH-1:0] in_comp_q, in_comp_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            err_q, err_d;

  logic [N_CH-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;

  ncl_rr_pick #(
    .N_CH          (N_CH),
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_pick (
    .elig    (data_cpl & ~in_comp_q),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    in_comp_d  = in_comp_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    err_d      = err_q | (|ill_ch);
    case (state_q)
      IDLE: begin
        if (!out_comp_s && pick_valid) begin
          out_data_d = in_data_s[pick_idx*DW +: DW];
          in_comp_d  = pick_oh;
          grant_d    = pick_idx;
          state_d    = DATA;
        end
      end
      DATA: begin
        // Word was captured at grant; later changes on the winner are not forwarded.
        if (out_comp_s && null_cpl[grant_q]) begin
          out_data_d = '0;
          in_comp_d  = '0;
          ptr_d      = grant_q;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        if (!out_comp_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q    <= IDLE;
      out_data_q <= '0;
      in_comp_q  <= '0;
      grant_q    <= '0;
      ptr_q      <= IW'(N_CH - 1);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      in_comp_q  <= in_comp_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
    end
  end

  assign out_data = out_data_q;
  assign in_comp  = in_comp_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);
  assign err_ill  = err_q;

endmodule

// File: tb/tb_ncl_sync_rr_merge.sv
// Directed bench for ncl_sync_rr_merge: a round-robin and a fixed-priority instance
// share stimulus; each channel can act as a four-phase producer reacting to in_comp.
module tb_ncl_sync_rr_merge;

  logic        clk = 1'b0;
  logic        init;
  logic [63:0] in_data_rr, in_data_fp;
  logic [3:0]  in_comp_rr, in_comp_fp;
  logic [15:0] out_data_rr, out_data_fp;
  logic        out_comp_rr, out_comp_fp;
  logic [1:0]  gid_rr, gid_fp;
  logic        busy_rr, busy_fp, err_rr, err_fp;

  logic [15:0] word [4];
  logic [3:0]  auto_ch;
  logic        dn_auto;
  logic        dn_man;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Producer model: an auto channel returns NULL while its in_comp is high.
  always_comb begin
    for (int i = 0; i < 4; i++)
      in_data_rr[i*16 +: 16] = (auto_ch[i] && in_comp_rr[i]) ? 16'h0 : word[i];
  end
  always_comb begin
    for (int i = 0; i < 4; i++)
      in_data_fp[i*16 +: 16] = (auto_ch[i] && in_comp_fp[i]) ? 16'h0 : word[i];
  end
  // Consumer model: requests NULL while it holds a DATA word.
  always_comb out_comp_rr = dn_auto ? (out_data_rr != 16'h0) : dn_man;
  always_comb out_comp_fp = dn_auto ? (out_data_fp != 16'h0) : dn_man;

  ncl_sync_rr_merge #(.N_CH(4), .W(8), .SYNC_STAGES(2), .PRIORITY_MODE(0)) dut (
    .clk(clk), .init(init), .in_data(in_data_rr), .in_comp(in_comp_rr),
    .out_data(out_data_rr), .out_comp(out_comp_rr), .grant_id(gid_rr),
    .busy(busy_rr), .err_ill(err_rr));

  ncl_sync_rr_merge #(.N_CH(4), .W(8), .SYNC_STAGES(2), .PRIORITY_MODE(1)) dut_fp (
    .clk(clk), .init(init), .in_data(in_data_fp), .in_comp(in_comp_fp),
    .out_data(out_data_fp), .out_comp(out_comp_fp), .grant_id(gid_fp),
    .busy(busy_fp), .err_ill(err_fp));

  function automatic logic [15:0] dr(input logic [7:0] v);
    logic [15:0] r;
    for (int j = 0; j < 8; j++) r[2*j +: 2] = v[j] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic do_reset();
    init    = 1'b1;
    auto_ch = 4'b0;
    dn_auto = 1'b0;
    dn_man  = 1'b0;
    for (int i = 0; i < 4; i++) word[i] = 16'h0;
    @(negedge clk);
    @(negedge clk);
    init = 1'b0;
  endtask

  // Waits for the next rising in_comp on the chosen instance; ok=0 on timeout.
  task automatic wait_grant(input bit fp, output int id, output bit ok);
    ok = 1'b0;
    id = -1;
    for (int n = 0; n < 200; n++) begin
      if ((fp ? in_comp_fp : in_comp_rr) == 4'b0) break;
      @(negedge clk);
    end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((fp ? in_comp_fp : in_comp_rr) != 4'b0) begin
        ok = 1'b1;
        id = fp ? int'(gid_fp) : int'(gid_rr);
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_data_rr !== 16'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data_rr); end
    checks++; if (in_comp_rr !== 4'b0) begin errors++; $display("FAIL reset_in_comp got=%b exp=0000", in_comp_rr); end
    checks++; if (gid_rr !== 2'd0) begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", gid_rr); end
    checks++; if (busy_rr !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_rr); end
    checks++; if (err_rr !== 1'b0) begin errors++; $display("FAIL reset_err_ill got=%b exp=0", err_rr); end
    checks++; if (out_data_fp !== 16'h0 || in_comp_fp !== 4'b0 || busy_fp !== 1'b0)
      begin errors++; $display("FAIL reset_fp got data=%h comp=%b busy=%b exp 0", out_data_fp, in_comp_fp, busy_fp); end
  endtask

  task automatic test_single_a5();
    int n;
    do_reset();
    word[2] = 16'h9966;  // dual-rail 0xA5
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); n++;
      if (out_data_rr != 16'h0) break;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL a5_latency got=%0d exp=3", n); end
    checks++; if (out_data_rr !== 16'h9966) begin errors++; $display("FAIL a5_out_data got=%h exp=9966", out_data_rr); end
    checks++; if (gid_rr !== 2'd2) begin errors++; $display("FAIL a5_grant_id got=%0d exp=2", gid_rr); end
    checks++; if (in_comp_rr !== 4'b0100) begin errors++; $display("FAIL a5_in_comp got=%b exp=0100", in_comp_rr); end
    checks++; if (busy_rr !== 1'b1) begin errors++; $display("FAIL a5_busy got=%b exp=1", busy_rr); end
    checks++; if (out_data_fp !== 16'h9966) begin errors++; $display("FAIL a5_fp_out_data got=%h exp=9966", out_data_fp); end
    dn_man  = 1'b1;
    word[2] = 16'h0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); n++;
      if (out_data_rr == 16'h0) break;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL a5_null_latency got=%0d exp=3", n); end
    checks++; if (in_comp_rr !== 4'b0) begin errors++; $display("FAIL a5_release_in_comp got=%b exp=0000", in_comp_rr); end
    checks++; if (busy_rr !== 1'b1) begin errors++; $display("FAIL a5_release_busy got=%b exp=1", busy_rr); end
    dn_man = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); n++;
      if (busy_rr == 1'b0) break;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL a5_idle_latency got=%0d exp=3", n); end
  endtask

  task automatic test_rr_order();
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    int id;
    bit ok;
    do_reset();
    word[0] = dr(8'h11); word[1] = dr(8'h22); word[2] = dr(8'h44); word[3] = dr(8'h88);
    auto_ch = 4'b1111;
    dn_auto = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(1'b0, id, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_grant_timeout idx=%0d got=none exp=%0d", k, exp_ord[k]); end
      checks++; if (id !== exp_ord[k]) begin errors++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, id, exp_ord[k]); end
      checks++; if (in_comp_rr !== (4'b0001 << exp_ord[k]))
        begin errors++; $display("FAIL rr_in_comp idx=%0d got=%b exp_ch=%0d", k, in_comp_rr, exp_ord[k]); end
      checks++; if (out_data_rr !== word[exp_ord[k]])
        begin errors++; $display("FAIL rr_out_data idx=%0d got=%h exp=%h", k, out_data_rr, word[exp_ord[k]]); end
    end
  endtask

  task automatic test_fixed_priority();
    int id;
    bit ok;
    do_reset();
    word[1] = dr(8'h3C);
    word[3] = dr(8'hC3);
    auto_ch = 4'b1010;
    dn_auto = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_grant(1'b1, id, ok);
      checks++; if (!ok || id !== 1) begin errors++; $display("FAIL fixed_ch1_only idx=%0d got=%0d exp=1", k, id); end
    end
    auto_ch[1] = 1'b0;
    word[1]    = 16'h0;
    wait_grant(1'b1, id, ok);
    wait_grant(1'b1, id, ok);
    checks++; if (!ok || id !== 3) begin errors++; $display("FAIL fixed_ch3_after got=%0d exp=3", id); end
    checks++; if (in_comp_fp !== 4'b1000) begin errors++; $display("FAIL fixed_ch3_in_comp got=%b exp=1000", in_comp_fp); end
    checks++; if (out_data_fp !== dr(8'hC3)) begin errors++; $display("FAIL fixed_ch3_data got=%h exp=%h", out_data_fp, dr(8'hC3)); end
  endtask

  task automatic test_partial_word();
    int n;
    do_reset();
    word[0] = 16'h5554;  // digit 0 still NULL
    for (int k = 0; k < 10; k++) @(negedge clk);
    checks++; if (busy_rr !== 1'b0) begin errors++; $display("FAIL partial_busy got=%b exp=0", busy_rr); end
    checks++; if (in_comp_rr !== 4'b0) begin errors++; $display("FAIL partial_in_comp got=%b exp=0000", in_comp_rr); end
    word[0] = 16'h5555;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); n++;
      if (busy_rr) break;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL partial_latency got=%0d exp=3", n); end
    checks++; if (out_data_rr !== 16'h5555) begin errors++; $display("FAIL partial_out_data got=%h exp=5555", out_data_rr); end
    checks++; if (gid_rr !== 2'd0) begin errors++; $display("FAIL partial_grant_id got=%0d exp=0", gid_rr); end
  endtask

  task automatic test_illegal();
    int id;
    bit ok;
    bit seen0, seen1;
    do_reset();
    word[3] = 16'h5755;  // digit 4 = 11
    @(negedge clk); @(negedge clk);
    checks++; if (err_rr !== 1'b0) begin errors++; $display("FAIL ill_early got=%b exp=0", err_rr); end
    @(negedge clk);
    checks++; if (err_rr !== 1'b1) begin errors++; $display("FAIL ill_set got=%b exp=1", err_rr); end
    word[0] = dr(8'h11);
    word[1] = dr(8'h22);
    auto_ch = 4'b0011;
    dn_auto = 1'b1;
    seen0 = 1'b0; seen1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_grant(1'b0, id, ok);
      checks++; if (!ok || id == 3 || in_comp_rr[3] !== 1'b0)
        begin errors++; $display("FAIL ill_grant idx=%0d got=%0d exp=not3", k, id); end
      if (id == 0) seen0 = 1'b1;
      if (id == 1) seen1 = 1'b1;
    end
    checks++; if (!(seen0 && seen1)) begin errors++; $display("FAIL ill_served got=%b%b exp=11", seen1, seen0); end
    checks++; if (err_rr !== 1'b1) begin errors++; $display("FAIL ill_sticky got=%b exp=1", err_rr); end
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    checks++; if (err_rr !== 1'b0) begin errors++; $display("FAIL ill_clear got=%b exp=0", err_rr); end
  endtask

  task automatic test_init_in_data();
    int id;
    bit ok;
    do_reset();
    word[1] = dr(8'h5A);
    wait_grant(1'b0, id, ok);
    checks++; if (!ok || id !== 1) begin errors++; $display("FAIL initd_grant got=%0d exp=1", id); end
    dn_man = 1'b1;
    for (int k = 0; k < 4; k++) @(negedge clk);
    checks++; if (busy_rr !== 1'b1 || out_data_rr !== dr(8'h5A))
      begin errors++; $display("FAIL initd_hold got busy=%b data=%h exp busy=1 data=%h", busy_rr, out_data_rr, dr(8'h5A)); end
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    checks++; if (out_data_rr !== 16'h0) begin errors++; $display("FAIL initd_out_data got=%h exp=0", out_data_rr); end
    checks++; if (in_comp_rr !== 4'b0) begin errors++; $display("FAIL initd_in_comp got=%b exp=0000", in_comp_rr); end
    checks++; if (busy_rr !== 1'b0) begin errors++; $display("FAIL initd_busy got=%b exp=0", busy_rr); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (busy_rr !== 1'b0 || in_comp_rr !== 4'b0)
        begin errors++; $display("FAIL initd_no_grant cyc=%0d got busy=%b comp=%b exp 0", k, busy_rr, in_comp_rr); end
    end
    dn_man = 1'b0;
    wait_grant(1'b0, id, ok);
    checks++; if (!ok || id !== 1) begin errors++; $display("FAIL initd_regrant got=%0d exp=1", id); end
  endtask

  initial begin
    init    = 1'b1;
    auto_ch = 4'b0;
    dn_auto = 1'b0;
    dn_man  = 1'b0;
    for (int i = 0; i < 4; i++) word[i] = 16'h0;
    test_reset();
    test_single_a5();
    test_rr_order();
    test_fixed_priority();
    test_partial_word();
    test_illegal();
    test_init_in_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
